// File: rtl/mux16_pkg.sv
// mux16_pkg: shared widths, FSM state type and scan-order constants (MUX16_MSB_FIRST_EN selects 15..0 order)
package mux16_pkg;
  localparam int NUM_CH = 16;
  localparam int SEL_W = 4;
  localparam int CNT_W = 8;
  typedef enum logic {IDLE, SHIFT} state_t;
`ifdef MUX16_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] FIRST_IDX = 4'd15;
  localparam logic [SEL_W-1:0] LAST_IDX = 4'd0;
`else
  localparam logic [SEL_W-1:0] FIRST_IDX = 4'd0;
  localparam logic [SEL_W-1:0] LAST_IDX = 4'd15;
`endif
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
`ifdef MUX16_MSB_FIRST_EN
    return idx - 4'd1;
`else
    return idx + 4'd1;
`endif
  endfunction
endpackage

// File: rtl/mux16_slot_timer.sv
// mux16_slot_timer: per-slot hold counter; ports clk, rst, clr (sync clear), en (count), slot_end (last hold cycle of a slot)
module mux16_slot_timer
  import mux16_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic slot_end
);
  logic [CNT_W-1:0] r_cnt;
  assign slot_end = en && (r_cnt == CNT_W'(HOLD_CYCLES - 1));
  always_ff @(posedge clk)
    if (rst || clr) r_cnt <= '0;
    else if (en) r_cnt <= slot_end ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/mux16_serializer.sv
// mux16_serializer: serializes a 16-bit word onto a/s0..s3 one channel per slot; ports clk, rst, din/din_valid/din_ready in, a, s0..s3 (s0=MSB), a_valid, frame_done out; MUX16_MSB_FIRST_EN scans 15..0
module mux16_serializer
  import mux16_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        a,
  output logic        s0,
  output logic        s1,
  output logic        s2,
  output logic        s3,
  output logic        a_valid,
  output logic        frame_done
);
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 256) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 1..256");
  end
  state_t r_state, w_next_state;
  logic [NUM_CH-1:0] r_word, w_next_word;
  logic [SEL_W-1:0] r_idx, w_next_idx, w_step_idx;
  logic r_a, w_next_a;
  logic r_a_valid, w_next_a_valid;
  logic r_frame_done, w_next_frame_done;
  logic w_shift, w_accept, w_slot_end;
  assign w_shift = (r_state == SHIFT);
  assign din_ready = !w_shift;
  assign w_accept = din_valid && din_ready;
  assign w_step_idx = next_idx(r_idx);
  mux16_slot_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(w_accept),
    .en(w_shift),
    .slot_end(w_slot_end)
  );
  always_comb begin
    w_next_state = r_state;
    w_next_word = r_word;
    w_next_idx = r_idx;
    w_next_a = r_a;
    w_next_a_valid = r_a_valid;
    w_next_frame_done = 1'b0;
    if (!w_shift) begin
      w_next_state = w_accept ? SHIFT : IDLE;
      w_next_word = w_accept ? din : r_word;
      w_next_idx = w_accept ? FIRST_IDX : '0;
      w_next_a = w_accept && din[FIRST_IDX];
      w_next_a_valid = w_accept;
    end else if (w_slot_end) begin
      // the last slot hands back to IDLE with a cleared bus and the done pulse
      w_next_state = (r_idx == LAST_IDX) ? IDLE : SHIFT;
      w_next_idx = (r_idx == LAST_IDX) ? '0 : w_step_idx;
      w_next_a = (r_idx != LAST_IDX) && r_word[w_step_idx];
      w_next_a_valid = (r_idx != LAST_IDX);
      w_next_frame_done = (r_idx == LAST_IDX);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_word <= '0;
      r_idx <= '0;
      r_a <= 1'b0;
      r_a_valid <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_word <= w_next_word;
      r_idx <= w_next_idx;
      r_a <= w_next_a;
      r_a_valid <= w_next_a_valid;
      r_frame_done <= w_next_frame_done;
    end
  end
  assign a = r_a;
  assign {s0, s1, s2, s3} = r_idx;
  assign a_valid = r_a_valid;
  assign frame_done = r_frame_done;
endmodule

// File: tb/tb_mux16_serializer.sv
// tb_mux16_serializer: cycle-stamped scoreboard bench for mux16_serializer
module tb_mux16_serializer;
  localparam int H = 3;
  typedef struct {
    int cyc;
    bit v;
    bit [3:0] s;
    bit a;
    bit done;
    bit [15:0] w;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] din = '0;
  logic din_valid = 1'b0;
  logic din_ready, a, s0, s1, s2, s3, a_valid, frame_done;
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int last_start = 0;
  bit mon_en = 1'b0;
  bit [15:0] rx = '0;
  bit [15:0] rw;
  bit rkeep;
  int rgap;
  exp_t q[$];
  mux16_serializer #(.HOLD_CYCLES(H)) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .a(a),
    .s0(s0),
    .s1(s1),
    .s2(s2),
    .s3(s3),
    .a_valid(a_valid),
    .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int slot_idx(input int c);
`ifdef MUX16_MSB_FIRST_EN
    return 15 - c;
`else
    return c;
`endif
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, expv);
  endtask
  task automatic push_frame(input bit [15:0] w, input int t0);
    exp_t e;
    for (int k = 0; k < 16 * H; k++) begin
      e.cyc = t0 + k;
      e.v = 1'b1;
      e.s = 4'(slot_idx(k / H));
      e.a = w[slot_idx(k / H)];
      e.done = 1'b0;
      e.w = w;
      q.push_back(e);
    end
    e.cyc = t0 + 16 * H;
    e.v = 1'b0;
    e.s = '0;
    e.a = 1'b0;
    e.done = 1'b1;
    e.w = w;
    q.push_back(e);
  endtask
  task automatic send(input bit [15:0] w, input bit keep);
    int t;
    t = 0;
    din = w;
    din_valid = 1'b1;
    while (!din_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!din_ready) begin
      n_checks++;
      $display("FAIL send_timeout cycle %0d: din_ready got 0 expected 1", cyc);
      din_valid = 1'b0;
      return;
    end
    last_start = cyc + 1;
    push_frame(w, last_start);
    @(negedge clk);
    if (!keep) din_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int t;
    t = 0;
    while (q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL idle_timeout cycle %0d: pending %0d expected 0", cyc, q.size());
    end
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      e.cyc = cyc;
      e.v = 1'b0;
      e.s = '0;
      e.a = 1'b0;
      e.done = 1'b0;
      e.w = '0;
      if (q.size() > 0 && q[0].cyc == cyc) e = q.pop_front();
      check("bus{ready,valid,s,a,done}", {24'b0, din_ready, a_valid, s0, s1, s2, s3, a, frame_done},
            {24'b0, !e.v, e.v, e.s, e.a, e.done});
      if (a_valid) rx[{s0, s1, s2, s3}] = a;
      if (e.done) begin
        check("loopback_word", {16'b0, rx}, {16'b0, e.w});
        rx = '0;
      end
    end
  end
  initial begin
    din = 16'hFFFF;
    din_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    din_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    send(16'hA5C3, 1'b0);
    wait_idle();
    send(16'h0001, 1'b0);
    send(16'h8000, 1'b0);
    wait_idle();
    send(16'hFFFF, 1'b1);
    send(16'h0000, 1'b0);
    wait_idle();
    send(16'h5A5A, 1'b0);
    while (cyc < last_start + 7 * H) @(negedge clk);
    rst = 1'b1;
    while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    send(16'h1234, 1'b0);
    for (int i = 0; i < 25; i++) begin
      rw = 16'($urandom);
      rkeep = 1'($urandom_range(0, 1));
      rgap = $urandom_range(0, 3);
      send(rw, (i == 24) ? 1'b0 : rkeep);
      if (!rkeep || i == 24) repeat (rgap) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
